// File: rtl/core_uart_apb.sv
// rtl/core_uart_apb.sv - APB slave UART with single TX/RX holding registers
//
// Purpose: 16x-oversampled UART with a zero-wait-state APB register
// interface, a 13-bit baud divisor with optional eighth-step fraction,
// 7/8 data bits, optional even/odd parity and one stop bit. Configuration
// comes from registers (FIXEDMODE=0) or from parameters (FIXEDMODE=1).
//
// Ports:
//   PCLK, PRESETN          clock, asynchronous active-low reset
//   PSEL PENABLE PWRITE    APB control
//   PADDR[4:0] PWDATA[7:0] APB address / write data
//   PRDATA[7:0]            APB read data (combinational)
//   PREADY, PSLVERR        tied 1 / 0
//   TX, RX                 serial line out / in
//   TXRDY RXRDY PARITY_ERR FRAMING_ERR OVERFLOW  status outputs
module core_uart_apb #(
  parameter int FAMILY            = 0,
  parameter int TX_FIFO           = 0,
  parameter int RX_FIFO           = 0,
  parameter int FIXEDMODE         = 0,
  parameter int BAUD_VALUE        = 1,
  parameter int PRG_BIT8          = 1,
  parameter int PRG_PARITY        = 0,
  parameter int RX_LEGACY_MODE    = 0,
  parameter int BAUD_VAL_FRCTN    = 0,
  parameter int BAUD_VAL_FRCTN_EN = 0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       TX,
  input  logic       RX,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERFLOW
);

  localparam logic        P_FIXED    = (FIXEDMODE != 0);
  localparam logic [12:0] P_BAUD     = BAUD_VALUE[12:0];
  localparam logic        P_BIT8     = (PRG_BIT8 != 0);
  localparam logic        P_PAR_EN   = (PRG_PARITY == 1) || (PRG_PARITY == 2);
  localparam logic        P_ODD      = (PRG_PARITY == 2);
  localparam logic [2:0]  P_FRCTN    = BAUD_VAL_FRCTN[2:0];
  localparam logic        P_FRCTN_EN = (BAUD_VAL_FRCTN_EN != 0);
  localparam logic        P_LEGACY   = (RX_LEGACY_MODE != 0);

  // FIFO depth and family tag have no functional effect.
  logic w_unused;
  assign w_unused = (^PADDR[1:0]) ^ (FAMILY != 0) ^ (TX_FIFO != 0) ^ (RX_FIFO != 0);

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  logic       w_wr;
  logic       w_rd_rx;
  assign w_wr    = PSEL & PENABLE & PWRITE;
  assign w_rd_rx = PSEL & PENABLE & ~PWRITE & (PADDR[4:2] == 3'd1);

  // ---------------- control registers ----------------
  logic [7:0] r_ctrl1;
  logic [7:0] r_ctrl2;
  logic [2:0] r_ctrl3;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_ctrl1 <= 8'h00;
      r_ctrl2 <= 8'h00;
      r_ctrl3 <= 3'd0;
    end else if (w_wr && !P_FIXED) begin
      case (PADDR[4:2])
        3'd2:    r_ctrl1 <= PWDATA;
        3'd3:    r_ctrl2 <= PWDATA;
        3'd5:    r_ctrl3 <= PWDATA[2:0];
        default: ;
      endcase
    end
  end

  logic [12:0] w_baud;
  logic        w_bit8;
  logic        w_par_en;
  logic        w_odd;
  logic [2:0]  w_frctn;
  logic [2:0]  w_last_idx;
  assign w_baud     = P_FIXED ? P_BAUD   : {r_ctrl2[7:3], r_ctrl1};
  assign w_bit8     = P_FIXED ? P_BIT8   : r_ctrl2[0];
  assign w_par_en   = P_FIXED ? P_PAR_EN : r_ctrl2[1];
  assign w_odd      = P_FIXED ? P_ODD    : r_ctrl2[2];
  assign w_frctn    = P_FIXED ? P_FRCTN  : r_ctrl3;
  assign w_last_idx = w_bit8 ? 3'd7 : 3'd6;

  // ---------------- status / receive data ----------------
  logic       r_txrdy;
  logic       r_rxrdy;
  logic       r_perr;
  logic       r_ovf;
  logic       r_ferr;
  logic [7:0] r_rx_data;

  always_comb begin
    PRDATA = 8'h00;
    if (PSEL && !PWRITE) begin
      case (PADDR[4:2])
        3'd1:    PRDATA = r_rx_data;
        3'd2:    PRDATA = w_baud[7:0];
        3'd3:    PRDATA = {w_baud[12:8], w_odd, w_par_en, w_bit8};
        3'd4:    PRDATA = {3'b000, r_ferr, r_ovf, r_perr, r_rxrdy, r_txrdy};
        3'd5:    PRDATA = {5'b00000, w_frctn};
        default: PRDATA = 8'h00;
      endcase
    end
  end

  // ---------------- baud generator ----------------
  // The first w_frctn ticks of every group of eight get one extra PCLK.
  logic [12:0] r_baud_cnt;
  logic [2:0]  r_frac_cnt;
  logic        r_stretch;
  logic        w_stretch_due;
  logic        w_tick;
  assign w_stretch_due = P_FRCTN_EN && (r_frac_cnt < w_frctn) && !r_stretch;
  assign w_tick        = (r_baud_cnt == 13'd0) && !w_stretch_due;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_baud_cnt <= 13'd0;
      r_frac_cnt <= 3'd0;
      r_stretch  <= 1'b0;
    end else if (r_baud_cnt != 13'd0) begin
      r_baud_cnt <= r_baud_cnt - 13'd1;
    end else if (w_stretch_due) begin
      r_stretch <= 1'b1;
    end else begin
      r_baud_cnt <= w_baud;
      r_stretch  <= 1'b0;
      r_frac_cnt <= r_frac_cnt + 3'd1;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  tx_state_t  r_tx_state;
  logic [7:0] r_tx_hold;
  logic       r_tx_pend;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_idx;
  logic [3:0] r_tx_tcnt;
  logic       r_tx_par;
  logic       r_tx;
  logic       w_tx_wr;
  assign w_tx_wr = w_wr && (PADDR[4:2] == 3'd0) && r_txrdy;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_tx_state <= T_IDLE;
      r_tx_hold  <= 8'h00;
      r_tx_pend  <= 1'b0;
      r_tx_shift <= 8'h00;
      r_tx_idx   <= 3'd0;
      r_tx_tcnt  <= 4'd0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_txrdy    <= 1'b1;
    end else begin
      if (w_tx_wr) begin
        r_tx_hold <= PWDATA;
        r_tx_pend <= 1'b1;
        r_txrdy   <= 1'b0;
      end
      case (r_tx_state)
        T_IDLE: begin
          // Frames start on a tick so every bit lasts exactly 16 ticks.
          if (r_tx_pend && w_tick) begin
            r_tx_pend  <= 1'b0;
            r_tx_shift <= r_tx_hold;
            r_tx_par   <= (^{w_bit8 & r_tx_hold[7], r_tx_hold[6:0]}) ^ w_odd;
            r_tx       <= 1'b0;
            r_tx_tcnt  <= 4'd0;
            r_tx_state <= T_START;
          end
        end
        default: begin
          if (w_tick) begin
            if (r_tx_tcnt != 4'd15) begin
              r_tx_tcnt <= r_tx_tcnt + 4'd1;
            end else begin
              r_tx_tcnt <= 4'd0;
              case (r_tx_state)
                T_START: begin
                  r_tx       <= r_tx_shift[0];
                  r_tx_idx   <= 3'd0;
                  r_tx_state <= T_DATA;
                end
                T_DATA: begin
                  if (r_tx_idx == w_last_idx) begin
                    r_tx       <= w_par_en ? r_tx_par : 1'b1;
                    r_tx_state <= w_par_en ? T_PAR : T_STOP;
                  end else begin
                    r_tx_idx   <= r_tx_idx + 3'd1;
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx       <= r_tx_shift[1];
                  end
                end
                T_PAR: begin
                  r_tx       <= 1'b1;
                  r_tx_state <= T_STOP;
                end
                T_STOP: begin
                  r_tx_state <= T_IDLE;
                  r_txrdy    <= 1'b1;
                end
                default: begin
                  r_tx       <= 1'b1;
                  r_tx_state <= T_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_HOLD, R_WAIT1} rx_state_t;
  rx_state_t  r_rx_state;
  logic       r_rx_s1;
  logic       r_rx_s2;
  logic       r_rx_prev;
  logic [7:0] r_rx_shift;
  logic [2:0] r_rx_idx;
  logic [3:0] r_rx_tcnt;
  logic       r_rx_acc;
  logic       r_rx_perr_pend;
  logic       r_rx_ferr_pend;

  logic       w_rx_fall;
  logic       w_rx_mid;
  logic       w_rx_done;
  logic       w_rx_ferr;
  logic [7:0] w_rx_byte;
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_mid  = w_tick && (r_rx_tcnt == 4'd15);
  assign w_rx_done = ((r_rx_state == R_STOP) && w_rx_mid && !P_LEGACY) ||
                     ((r_rx_state == R_HOLD) && w_tick && (r_rx_tcnt == 4'd7));
  assign w_rx_ferr = (r_rx_state == R_STOP) ? ~r_rx_s2 : r_rx_ferr_pend;
  // In 7-bit mode the first bit has only been shifted down to bit 1.
  assign w_rx_byte = w_bit8 ? r_rx_shift : {1'b0, r_rx_shift[7:1]};

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_rx_s1        <= 1'b1;
      r_rx_s2        <= 1'b1;
      r_rx_prev      <= 1'b1;
      r_rx_state     <= R_IDLE;
      r_rx_shift     <= 8'h00;
      r_rx_idx       <= 3'd0;
      r_rx_tcnt      <= 4'd0;
      r_rx_acc       <= 1'b0;
      r_rx_perr_pend <= 1'b0;
      r_rx_ferr_pend <= 1'b0;
    end else begin
      r_rx_s1   <= RX;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        R_IDLE: begin
          if (w_rx_fall) begin
            r_rx_tcnt  <= 4'd0;
            r_rx_state <= R_START;
          end
        end
        R_START: begin
          if (w_tick) begin
            if (r_rx_tcnt == 4'd7) begin
              // Line back high at the start-bit midpoint is a glitch.
              if (!r_rx_s2) begin
                r_rx_tcnt      <= 4'd0;
                r_rx_idx       <= 3'd0;
                r_rx_acc       <= 1'b0;
                r_rx_perr_pend <= 1'b0;
                r_rx_ferr_pend <= 1'b0;
                r_rx_state     <= R_DATA;
              end else begin
                r_rx_state <= R_IDLE;
              end
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 4'd1;
            end
          end
        end
        R_DATA: begin
          if (w_tick) begin
            if (w_rx_mid) begin
              r_rx_tcnt  <= 4'd0;
              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
              r_rx_acc   <= r_rx_acc ^ r_rx_s2;
              if (r_rx_idx == w_last_idx) begin
                r_rx_state <= w_par_en ? R_PAR : R_STOP;
              end else begin
                r_rx_idx <= r_rx_idx + 3'd1;
              end
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 4'd1;
            end
          end
        end
        R_PAR: begin
          if (w_tick) begin
            if (w_rx_mid) begin
              r_rx_tcnt      <= 4'd0;
              r_rx_perr_pend <= r_rx_acc ^ r_rx_s2 ^ w_odd;
              r_rx_state     <= R_STOP;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 4'd1;
            end
          end
        end
        R_STOP: begin
          if (w_tick) begin
            if (w_rx_mid) begin
              r_rx_tcnt      <= 4'd0;
              r_rx_ferr_pend <= ~r_rx_s2;
              if (P_LEGACY)     r_rx_state <= R_HOLD;
              else if (r_rx_s2) r_rx_state <= R_IDLE;
              else              r_rx_state <= R_WAIT1;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 4'd1;
            end
          end
        end
        R_HOLD: begin
          if (w_tick) begin
            if (r_rx_tcnt == 4'd7) begin
              r_rx_state <= r_rx_ferr_pend ? R_WAIT1 : R_IDLE;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 4'd1;
            end
          end
        end
        R_WAIT1: begin
          if (r_rx_s2) r_rx_state <= R_IDLE;
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  // A completing byte wins over a same-cycle RXDATA read.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_rxrdy   <= 1'b0;
      r_perr    <= 1'b0;
      r_ovf     <= 1'b0;
      r_ferr    <= 1'b0;
      r_rx_data <= 8'h00;
    end else if (w_rx_done) begin
      if (r_rxrdy) begin
        r_ovf <= 1'b1;
      end else begin
        r_rx_data <= w_rx_byte;
        r_rxrdy   <= 1'b1;
        r_perr    <= r_rx_perr_pend;
        r_ferr    <= w_rx_ferr;
      end
    end else if (w_rd_rx) begin
      r_rxrdy <= 1'b0;
      r_perr  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end
  end

  assign TX          = r_tx;
  assign TXRDY       = r_txrdy;
  assign RXRDY       = r_rxrdy;
  assign PARITY_ERR  = r_perr;
  assign FRAMING_ERR = r_ferr;
  assign OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_core_uart_apb.sv
// tb/tb_core_uart_apb.sv - two-instance loopback bench for core_uart_apb
module tb_core_uart_apb;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       psel1, psel2, penable, pwrite;
  logic [4:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata1, prdata2;
  logic       pready1, pready2, pslverr1, pslverr2;
  logic       tx1, tx2, rx2, rx2_force0;
  logic       txrdy1, rxrdy1, perr1, ferr1, ovf1;
  logic       txrdy2, rxrdy2, perr2, ferr2, ovf2;

  assign rx2 = rx2_force0 ? 1'b0 : tx1;

  core_uart_apb dut1 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
    .TX(tx1), .RX(tx2), .TXRDY(txrdy1), .RXRDY(rxrdy1), .PARITY_ERR(perr1),
    .FRAMING_ERR(ferr1), .OVERFLOW(ovf1)
  );

  core_uart_apb dut2 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2),
    .TX(tx2), .RX(rx2), .TXRDY(txrdy2), .RXRDY(rxrdy2), .PARITY_ERR(perr2),
    .FRAMING_ERR(ferr2), .OVERFLOW(ovf2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] st;   // expected STATUS bits 4:1
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input int dev, input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    psel1 = (dev == 1); psel2 = (dev == 2);
    pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel1 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input int dev, input logic [4:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    psel1 = (dev == 1); psel2 = (dev == 2);
    pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = (dev == 1) ? prdata1 : prdata2;
    @(posedge clk); #1;
    psel1 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  task automatic configure(input int dev, input logic [7:0] c1, input logic [7:0] c2);
    apb_write(dev, 5'h08, c1);
    apb_write(dev, 5'h0C, c2);
  endtask

  // which: 0 = RXRDY of dut2, 1 = TXRDY of dut1, 2 = OVERFLOW of dut2
  task automatic wait_for(input int which, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = rxrdy2;
        1:       hit = txrdy1;
        default: hit = ovf2;
      endcase
    end
    check({tag, " wait"}, {31'd0, hit}, 32'd1);
  endtask

  // bits[0] is the start bit; bits are sampled near their middle (32 PCLK per bit).
  task automatic frame_check(input logic [10:0] bits, input int nb, input string tag);
    bit fell = 1'b0;
    for (int i = 0; i < 300 && !fell; i++) begin
      @(negedge clk);
      fell = !tx1;
    end
    check({tag, " start edge"}, {31'd0, fell}, 32'd1);
    if (fell) begin
      repeat (16) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
        check($sformatf("%s bit%0d", tag, k), {31'd0, tx1}, {31'd0, bits[k]});
        if (k != nb - 1) repeat (32) @(negedge clk);
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp_data, input logic [7:0] exp_st);
    sb_q.push_back({exp_data, exp_st});
    apb_write(1, 5'h00, d);
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t       e;
    logic [7:0] st, d;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      apb_read(2, 5'h10, st);
      check({tag, " status"}, {24'd0, st & 8'h1E}, {24'd0, e.st});
      apb_read(2, 5'h04, d);
      check({tag, " rxdata"}, {24'd0, d}, {24'd0, e.data});
      @(negedge clk);
      check({tag, " flags cleared"}, {28'd0, ovf2, ferr2, perr2, rxrdy2}, 32'd0);
    end
  endtask

  logic [7:0] rd;

  initial begin
    rst_n = 1'b1;
    psel1 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 5'd0; pwdata = 8'd0; rx2_force0 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset tx", {31'd0, tx1}, 32'd1);
    check("reset txrdy", {31'd0, txrdy1}, 32'd1);
    check("reset rx flags", {28'd0, ovf2, ferr2, perr2, rxrdy2}, 32'd0);
    check("pready/pslverr", {30'd0, pready1, pslverr1}, 32'd2);
    check("prdata idle", {24'd0, prdata1}, 32'd0);
    apb_read(1, 5'h10, rd);
    check("reset status", {24'd0, rd}, 32'h01);
    apb_read(2, 5'h04, rd);
    check("reset rxdata", {24'd0, rd}, 32'h00);
    apb_read(1, 5'h08, rd);
    check("reset ctrl1", {24'd0, rd}, 32'h00);

    // 8N1, baud divisor 1 -> 32 PCLK per bit
    configure(1, 8'h01, 8'h01);
    configure(2, 8'h01, 8'h01);
    apb_read(1, 5'h0C, rd);
    check("ctrl2 readback", {24'd0, rd}, 32'h01);

    send(8'h55, 8'h55, 8'h02);
    check("txrdy drop", {31'd0, txrdy1}, 32'd0);
    frame_check({1'b0, 1'b1, 8'h55, 1'b0}, 10, "frame55");
    apb_write(1, 5'h00, 8'hAA);   // TXRDY still low: must be dropped
    wait_for(0, 200, "rx55");
    sb_pop_check("byte55");
    wait_for(1, 200, "txrdy55");
    repeat (400) @(negedge clk);
    check("busy write dropped", {31'd0, rxrdy2}, 32'd0);

    // even parity transmit, odd parity receive
    configure(1, 8'h01, 8'h03);
    configure(2, 8'h01, 8'h07);
    send(8'hA3, 8'hA3, 8'h06);
    wait_for(0, 600, "rxA3");
    check("parity err pin", {31'd0, perr2}, 32'd1);
    sb_pop_check("parityA3");
    wait_for(1, 200, "txrdyA3");

    // line held low: framing error, zero byte stored
    configure(1, 8'h01, 8'h01);
    configure(2, 8'h01, 8'h01);
    sb_q.push_back({8'h00, 8'h12});
    rx2_force0 = 1'b1;
    wait_for(0, 600, "rxbreak");
    check("framing err pin", {31'd0, ferr2}, 32'd1);
    rx2_force0 = 1'b0;
    repeat (4) @(negedge clk);
    sb_pop_check("framing");

    // overflow: second byte discarded
    send(8'h11, 8'h11, 8'h0A);
    wait_for(0, 600, "rx11");
    wait_for(1, 200, "txrdy11");
    apb_write(1, 5'h00, 8'h22);
    wait_for(2, 600, "overflow");
    sb_pop_check("overflow");
    wait_for(1, 200, "txrdy22");

    // reset in the middle of a frame
    apb_write(1, 5'h00, 8'h00);
    repeat (100) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midframe reset tx", {31'd0, tx1}, 32'd1);
    check("midframe reset txrdy", {31'd0, txrdy1}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apb_read(1, 5'h08, rd);
    check("ctrl1 after reset", {24'd0, rd}, 32'h00);
    configure(1, 8'h01, 8'h01);
    configure(2, 8'h01, 8'h01);
    send(8'h0F, 8'h0F, 8'h02);
    frame_check({1'b0, 1'b1, 8'h0F, 1'b0}, 10, "frame0F");
    wait_for(0, 200, "rx0F");
    sb_pop_check("byte0F");
    wait_for(1, 200, "txrdy0F");

    // 7 data bits
    configure(1, 8'h01, 8'h00);
    configure(2, 8'h01, 8'h00);
    send(8'hFF, 8'h7F, 8'h02);
    frame_check({2'b00, 1'b1, 7'h7F, 1'b0}, 9, "frame7");
    wait_for(0, 200, "rx7F");
    sb_pop_check("byte7F");

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule
